fc_weight_feeder: RTL and testbench
===================================

FC_WEIGHT_FEEDER -- requirements
Module: fc_weight_feeder

Interface
REQ-001 Parameter QZ, 16, bit width of one weight lane.
REQ-002 Parameter LANES, 4, number of weight lanes per word (one per gate).
REQ-003 Parameter DEPTH, 16, FIFO depth in words; power of two, at least 2.
REQ-004 Parameter hidden_size, 512, matrix dimension; one matrix pass is hidden_size*hidden_size words.
REQ-005 The block SHALL use reset rst_n (asynchronous, active-low) and clock clk.
REQ-006 Port clk  input  1  clock.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port wr_data  input  QZ*LANES  weight word from the SPI loader; lane i is bits [QZ*(i+1)-1:QZ*i].
REQ-009 Port wr_valid  input  1  push strobe for wr_data.
REQ-010 Port wr_ready  output  1  high when the FIFO is not full.
REQ-011 Port rd_busy  input  1  word request level from the MAC engine.
REQ-012 Port fifo_ready  output  1  one-cycle grant pulse.
REQ-013 Port whh  output  QZ*LANES  registered weight word.
REQ-014 Port whh_valid  output  1  one-cycle strobe qualifying whh.
REQ-015 Port clear  input  1  synchronous restart, driven from new_cal.
REQ-016 Port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 Port done  output  1  high once a full matrix pass has been issued.
REQ-018 Port overflow  output  1  sticky; set by a push while full.

Function
REQ-019 FIFO: push when wr_valid is high and the FIFO is not full; pop only on an issue (REQ-022); read and write pointers wrap modulo DEPTH.
REQ-020 If push and pop occur in the same cycle, level SHALL be unchanged; a push while full is allowed when a pop occurs in the same cycle.
REQ-021 A push while full with no pop SHALL drop the word and set overflow; FIFO contents SHALL be unchanged.
REQ-022 Issue FSM states: IDLE, GRANT, WAIT_DROP, DONE.
- IDLE -> GRANT when rd_busy is high, level > 0 and done is low.
- The GRANT cycle pops the head word into whh and drives fifo_ready=1 and whh_valid=1 for exactly that cycle.
REQ-023 Latency: rd_busy is sampled high with a non-empty FIFO at edge N; fifo_ready and whh_valid are high in the cycle following edge N.
- If the FIFO is empty, wait in IDLE with no pulse, then grant the cycle after the first push becomes visible in level.
REQ-024 GRANT -> WAIT_DROP, or -> DONE if this issue was word number hidden_size*hidden_size.
- WAIT_DROP -> IDLE only after rd_busy has been sampled low, so one request yields exactly one grant.
REQ-025 whh SHALL hold its value until the next GRANT.
REQ-026 The issue counter SHALL be wide enough for hidden_size*hidden_size, increment once per GRANT, and never wrap.
REQ-027 In DONE: done=1, no grants, rd_busy ignored, pushes still accepted.
REQ-028 clear has priority over push, pop and state changes. On the next edge it SHALL:
- empty the FIFO, with pointers and level set to 0;
- zero the issue counter;
- set done=0 and overflow=0;
- set state to IDLE.
whh SHALL retain its value through clear.
REQ-029 wr_ready = (level != DEPTH), combinational from registered level.

Reset
REQ-030 While rst_n is low:
- state is IDLE; pointers, level and counter are 0;
- whh is 0; fifo_ready, whh_valid, done and overflow are 0;
- wr_ready is 1.
REQ-031 Reset asserted mid-grant SHALL abort the grant; the FIFO contents are lost.

Verification
REQ-032 Push 3 words (0x0001_0002_0003_0004, ...), hold rd_busy=1 for 1 cycle -> one fifo_ready/whh_valid pulse next cycle, whh=0x0001_0002_0003_0004, level=2.
REQ-033 Hold rd_busy=1 for 5 cycles without dropping it -> exactly one grant; after rd_busy drops low for 1 cycle and rises again -> second word issued.
REQ-034 Request with an empty FIFO, push a word 4 cycles later -> grant exactly once, the cycle after level becomes 1.
REQ-035 With DEPTH=16, push 17 words without pops -> wr_ready=0 after the 16th push, overflow=1 after the 17th, level=16; then push and grant in the same cycle -> level stays 16 and overflow stays 1.
REQ-036 With hidden_size=2, issue 4 words -> done=1 after the 4th grant; a 5th request gives no pulse; clear -> done=0, level=0, next request is served after a push.
REQ-037 Assert rst_n low during a GRANT cycle with level=5 -> all outputs return to reset values and level=0.

Source files
------------

// File: rtl/fc_weight_feeder_if.sv
// -----------------------------------------------------------------------------
// fc_weight_feeder_if
// Bundles the weight-feeder handshake signals between the SPI loader / MAC
// engine side (master) and the feeder itself (slave).
//   wr_data/wr_valid/wr_ready : push side from the SPI loader
//   rd_busy/fifo_ready        : request level and one-cycle grant pulse
//   whh/whh_valid             : registered weight word and its strobe
//   clear                     : synchronous restart (new_cal)
//   level/done/overflow       : occupancy, pass-complete flag, sticky overflow
// -----------------------------------------------------------------------------
interface fc_weight_feeder_if #(
  parameter int QZ    = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 16
);
  localparam int W     = QZ * LANES;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             rd_busy;
  logic             fifo_ready;
  logic [W-1:0]     whh;
  logic             whh_valid;
  logic             clear;
  logic [LVL_W-1:0] level;
  logic             done;
  logic             overflow;

  modport master (
    output wr_data, wr_valid, rd_busy, clear,
    input  wr_ready, fifo_ready, whh, whh_valid, level, done, overflow
  );

  modport slave (
    input  wr_data, wr_valid, rd_busy, clear,
    output wr_ready, fifo_ready, whh, whh_valid, level, done, overflow
  );
endinterface

// File: rtl/fc_weight_feeder.sv
// -----------------------------------------------------------------------------
// fc_weight_feeder
// Buffers weight words from the SPI loader in a DEPTH-word FIFO and hands them
// to the MAC engine one word per request. A request is the rd_busy level; each
// rising request yields exactly one grant (fifo_ready + whh_valid pulse with
// the word registered on whh). After hidden_size*hidden_size grants the block
// parks in DONE until clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fc_weight_feeder_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module fc_weight_feeder #(
  parameter int QZ          = 16,
  parameter int LANES       = 4,
  parameter int DEPTH       = 16,
  parameter int hidden_size = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  fc_weight_feeder_if.slave   bus
);
  localparam int W     = QZ * LANES;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TOTAL = hidden_size * hidden_size;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DROP, DONE} state_e;

  logic [W-1:0]     mem [DEPTH];

  state_e           state_q,      state_d;
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [LVL_W-1:0] level_q,      level_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [W-1:0]     whh_q,        whh_d;
  logic             fifo_ready_q, fifo_ready_d;
  logic             whh_valid_q,  whh_valid_d;
  logic             done_q,       done_d;
  logic             overflow_q,   overflow_d;

  logic full;
  logic issue;
  logic push;
  logic drop;

  assign full  = (level_q == LVL_W'(DEPTH));
  // The pop happens on the edge that enters GRANT, so the popped word and the
  // reduced level are both visible during the GRANT cycle itself.
  assign issue = (state_q == IDLE) && bus.rd_busy && (level_q != '0) && !done_q;
  // A full FIFO still accepts a word when the same edge frees a slot.
  assign push  = bus.wr_valid && (!full || issue) && !bus.clear;
  assign drop  = bus.wr_valid && full && !issue;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    whh_d        = whh_q;
    fifo_ready_d = 1'b0;
    whh_valid_d  = 1'b0;
    done_d       = done_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d      = GRANT;
          whh_d        = mem[rd_ptr_q];
          rd_ptr_d     = rd_ptr_q + PTR_W'(1);
          cnt_d        = cnt_q + CNT_W'(1);
          fifo_ready_d = 1'b1;
          whh_valid_d  = 1'b1;
        end
      end
      GRANT: begin
        if (cnt_q == CNT_W'(TOTAL)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_DROP;
        end
      end
      // Re-arm only after the request has gone low, so a held request is
      // served once.
      WAIT_DROP: if (!bus.rd_busy) state_d = IDLE;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    unique case ({push, issue})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop) overflow_d = 1'b1;

    // Restart wins over everything; whh deliberately keeps its last word.
    if (bus.clear) begin
      state_d      = IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      cnt_d        = '0;
      whh_d        = whh_q;
      fifo_ready_d = 1'b0;
      whh_valid_d  = 1'b0;
      done_d       = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      whh_q        <= '0;
      fifo_ready_q <= 1'b0;
      whh_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      whh_q        <= whh_d;
      fifo_ready_q <= fifo_ready_d;
      whh_valid_q  <= whh_valid_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; zeroed pointers and level make its
  // contents unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.wr_ready   = !full;
  assign bus.fifo_ready = fifo_ready_q;
  assign bus.whh        = whh_q;
  assign bus.whh_valid  = whh_valid_q;
  assign bus.level      = level_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fc_weight_feeder.sv
// -----------------------------------------------------------------------------
// tb_fc_weight_feeder
// Directed scenarios with random weight words. Expected words and occupancy
// come from a queue holding what the FIFO should contain; grant timing and the
// done/overflow flags are stated from the block's behavioural rules.
// -----------------------------------------------------------------------------
module tb_fc_weight_feeder;
  localparam int QZ    = 16;
  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int HS    = 2;
  localparam int W     = QZ * LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_weight_feeder_if #(.QZ(QZ), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  fc_weight_feeder #(
    .QZ(QZ), .LANES(LANES), .DEPTH(DEPTH), .hidden_size(HS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  int p0;

  logic [W-1:0] q [$];
  logic [W-1:0] w;
  logic [W-1:0] last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  // Drive inputs, advance one edge, sample 1 time unit later.
  task automatic step(input bit wv, input logic [W-1:0] d, input bit busy, input bit clr);
    bus.wr_valid = wv;
    bus.wr_data  = d;
    bus.rd_busy  = busy;
    bus.clear    = clr;
    @(posedge clk);
    #1;
    if (bus.fifo_ready) pulses++;
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    q.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_busy  = 1'b0;
    bus.clear    = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_level",      64'(bus.level),      64'd0);
    check("rst_wr_ready",   64'(bus.wr_ready),   64'd1);
    check("rst_fifo_ready", 64'(bus.fifo_ready), 64'd0);
    check("rst_whh_valid",  64'(bus.whh_valid),  64'd0);
    check("rst_done",       64'(bus.done),       64'd0);
    check("rst_overflow",   64'(bus.overflow),   64'd0);
    check("rst_whh",        64'(bus.whh),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three pushes, single-cycle request
    push(64'h0001_0002_0003_0004);
    push(rnd());
    push(rnd());
    check("level_3", 64'(bus.level), 64'd3);
    step(1'b0, '0, 1'b1, 1'b0);
    last = q.pop_front();
    check("g1_fifo_ready", 64'(bus.fifo_ready), 64'd1);
    check("g1_whh_valid",  64'(bus.whh_valid),  64'd1);
    check("g1_whh",        64'(bus.whh),        64'(last));
    check("g1_level",      64'(bus.level),      64'(q.size()));
    idle(1);
    check("g1_pulse_end",  64'(bus.fifo_ready), 64'd0);
    check("g1_whh_hold",   64'(bus.whh),        64'(last));
    idle(1 + $urandom_range(0, 2));

    // Held request yields one grant; drop and re-raise yields the next
    p0 = pulses;
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    check("held_one_grant", 64'(pulses - p0), 64'd1);
    last = q.pop_front();
    check("held_whh",       64'(bus.whh),     64'(last));
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    last = q.pop_front();
    check("rearm_grant", 64'(bus.fifo_ready), 64'd1);
    check("rearm_whh",   64'(bus.whh),        64'(last));
    check("rearm_level", 64'(bus.level),      64'(q.size()));
    idle(2);

    // Clear restarts the pass counter
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr1_level", 64'(bus.level), 64'd0);
    check("clr1_done",  64'(bus.done),  64'd0);

    // Request while empty, push four cycles later
    p0 = pulses;
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    check("empty_no_grant", 64'(pulses - p0), 64'd0);
    w = rnd();
    step(1'b1, w, 1'b1, 1'b0);
    q.push_back(w);
    check("empty_level_1",  64'(bus.level),      64'd1);
    check("empty_not_yet",  64'(bus.fifo_ready), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    last = q.pop_front();
    check("empty_grant",    64'(bus.fifo_ready), 64'd1);
    check("empty_whh",      64'(bus.whh),        64'(last));
    check("empty_level_0",  64'(bus.level),      64'd0);
    idle(2);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      push(rnd());
      if (i == DEPTH - 2) check("wr_ready_15", 64'(bus.wr_ready), 64'd1);
    end
    check("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("full_level",    64'(bus.level),    64'(DEPTH));
    check("full_no_ovf",   64'(bus.overflow), 64'd0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    check("ovf_set",       64'(bus.overflow), 64'd1);
    check("ovf_level",     64'(bus.level),    64'(DEPTH));
    // Push and grant on the same edge while full
    w = rnd();
    step(1'b1, w, 1'b1, 1'b0);
    last = q.pop_front();
    q.push_back(w);
    check("pp_grant",      64'(bus.fifo_ready), 64'd1);
    check("pp_whh",        64'(bus.whh),        64'(last));
    check("pp_level",      64'(bus.level),      64'(DEPTH));
    check("pp_ovf_sticky", 64'(bus.overflow),   64'd1);
    idle(2);

    // Grants 3 and 4 complete the pass (hidden_size = 2)
    for (int g = 3; g <= HS * HS; g++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      last = q.pop_front();
      check("pass_grant", 64'(bus.fifo_ready), 64'd1);
      check("pass_whh",   64'(bus.whh),        64'(last));
      idle(2);
    end
    check("done_set",   64'(bus.done),  64'd1);
    check("done_level", 64'(bus.level), 64'(q.size()));
    p0 = pulses;
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    check("done_no_grant", 64'(pulses - p0), 64'd0);
    w = rnd();
    step(1'b1, w, 1'b0, 1'b0);
    q.push_back(w);
    check("done_push_ok", 64'(bus.level), 64'(q.size()));

    // Clear with a concurrent push: clear wins, whh retained
    step(1'b1, rnd(), 1'b0, 1'b1);
    q.delete();
    check("clr2_done",  64'(bus.done),     64'd0);
    check("clr2_level", 64'(bus.level),    64'd0);
    check("clr2_ovf",   64'(bus.overflow), 64'd0);
    check("clr2_whh",   64'(bus.whh),      64'(last));
    w = rnd();
    push(w);
    step(1'b0, '0, 1'b1, 1'b0);
    last = q.pop_front();
    check("post_clr_grant", 64'(bus.fifo_ready), 64'd1);
    check("post_clr_whh",   64'(bus.whh),        64'(last));
    idle(2);

    // Reset asserted during a GRANT cycle with level 5
    for (int i = 0; i < 6; i++) push(rnd());
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_grant", 64'(bus.fifo_ready), 64'd1);
    check("pre_rst_level", 64'(bus.level),      64'd5);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst_fifo_ready", 64'(bus.fifo_ready), 64'd0);
    check("mid_rst_whh_valid",  64'(bus.whh_valid),  64'd0);
    check("mid_rst_whh",        64'(bus.whh),        64'd0);
    check("mid_rst_level",      64'(bus.level),      64'd0);
    check("mid_rst_wr_ready",   64'(bus.wr_ready),   64'd1);
    check("mid_rst_done",       64'(bus.done),       64'd0);
    check("mid_rst_ovf",        64'(bus.overflow),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w = rnd();
    push(w);
    step(1'b0, '0, 1'b1, 1'b0);
    last = q.pop_front();
    check("post_rst_whh",   64'(bus.whh),   64'(last));
    check("post_rst_level", 64'(bus.level), 64'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
